// File: rtl/htif_pkg.sv
// htif_pkg: shared definitions for the htif serial byte protocol.
// Used by the host initiator (htif_host) and the far-end bus bridge.
//   - command byte constants
//   - host FSM state encoding
//   - byte_of(): little-endian byte select helper
package htif_pkg;

  localparam logic [7:0] HTIF_CMD_ADDR   = 8'h61; // 'a'
  localparam logic [7:0] HTIF_CMD_READ   = 8'h72; // 'r'
  localparam logic [7:0] HTIF_CMD_WRITE  = 8'h77; // 'w'
  localparam logic [7:0] HTIF_CMD_READ2  = 8'h52; // 'R'
  localparam logic [7:0] HTIF_CMD_WRITE2 = 8'h57; // 'W'

  // Each 4-byte field occupies an aligned block of four codes so the
  // low two state bits give the byte index inside the field.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR_CMD = 4'd1,
    ST_OP_CMD   = 4'd2,
    ST_ADDR0    = 4'd4,
    ST_ADDR1    = 4'd5,
    ST_ADDR2    = 4'd6,
    ST_ADDR3    = 4'd7,
    ST_WDATA0   = 4'd8,
    ST_WDATA1   = 4'd9,
    ST_WDATA2   = 4'd10,
    ST_WDATA3   = 4'd11,
    ST_RDATA0   = 4'd12,
    ST_RDATA1   = 4'd13,
    ST_RDATA2   = 4'd14,
    ST_RDATA3   = 4'd15
  } htif_state_e;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction

endpackage

// File: rtl/htif_host.sv
// htif_host: host-side initiator for the htif serial byte protocol.
// Serialises single-word read/write requests into 'a' A0..A3, 'r' / 'w' D0..D3
// and reassembles the 4-byte read reply. All multi-byte fields LSB first.
//
// Parameters:
//   TIMEOUT  cycles allowed per read-reply byte; 0 disables the timeout
// Optional build macro:
//   HTIF_ADDR_CACHE_EN  skip the 'a' sequence when the far end's auto-incremented
//                       address already matches the request
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   req_valid/ready/write/address/data local request port
//   res_valid/data/error               one-cycle response pulse
//   tx_valid/ready/data                byte stream to far end
//   rx_valid/ready/data                byte stream from far end
module htif_host
  import htif_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_error,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        rx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  htif_state_e r_state;
  logic        r_req_ready;
  logic        r_res_valid;
  logic        r_res_error;
  logic [31:0] r_res_data;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_rx_ready;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_tmo_cnt;

  logic        w_tx_hs;
  logic        w_rx_hs;
  logic        w_hit;
  logic        w_timeout;
  logic [1:0]  w_idx;
  logic [1:0]  w_idx_nxt;
  logic [31:0] w_tmo_nxt;
  logic [7:0]  w_op_byte;

  assign w_tx_hs   = r_tx_valid & tx_ready;
  assign w_rx_hs   = rx_valid & r_rx_ready;
  assign w_idx     = r_state[1:0];
  assign w_idx_nxt = w_idx + 2'd1;
  assign w_tmo_nxt = r_tmo_cnt + 32'd1;
  assign w_op_byte = r_write ? HTIF_CMD_WRITE : HTIF_CMD_READ;
  // rx_ready is high exactly in RDATA0-3, so it doubles as the "waiting" flag.
  assign w_timeout = (TIMEOUT != 0) && r_rx_ready && !w_rx_hs &&
                     (w_tmo_nxt == 32'(TIMEOUT));

`ifdef HTIF_ADDR_CACHE_EN
  // Shadow of the far end's address register: valid once a full 'a' sequence
  // has gone out, bumped by 4 per completed access, lost on a read timeout
  // since the far end may be mid-reply.
  logic [31:0] r_cur_addr;
  logic        r_addr_valid;
  logic        w_done;

  assign w_done = ((r_state == ST_WDATA3) && w_tx_hs) ||
                  ((r_state == ST_RDATA3) && w_rx_hs);
  assign w_hit  = r_addr_valid && (req_address == r_cur_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cur_addr   <= '0;
      r_addr_valid <= 1'b0;
    end else if ((r_state == ST_ADDR3) && w_tx_hs) begin
      r_cur_addr   <= r_addr;
      r_addr_valid <= 1'b1;
    end else if (w_done) begin
      r_cur_addr   <= r_cur_addr + 32'd4;
    end else if (w_timeout) begin
      r_addr_valid <= 1'b0;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_error <= 1'b0;
      r_res_data  <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_rx_ready  <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && req_valid) begin
            r_req_ready <= 1'b0;
            r_write     <= req_write;
            r_addr      <= req_address;
            r_wdata     <= req_data;
            r_tx_valid  <= 1'b1;
            if (w_hit) begin
              r_state   <= ST_OP_CMD;
              r_tx_data <= req_write ? HTIF_CMD_WRITE : HTIF_CMD_READ;
            end else begin
              r_state   <= ST_ADDR_CMD;
              r_tx_data <= HTIF_CMD_ADDR;
            end
          end
        end
        ST_ADDR_CMD: if (w_tx_hs) begin
          r_state   <= ST_ADDR0;
          r_tx_data <= byte_of(r_addr, 2'd0);
        end
        ST_ADDR0, ST_ADDR1, ST_ADDR2: if (w_tx_hs) begin
          r_state   <= htif_state_e'(r_state + 4'd1);
          r_tx_data <= byte_of(r_addr, w_idx_nxt);
        end
        ST_ADDR3: if (w_tx_hs) begin
          r_state   <= ST_OP_CMD;
          r_tx_data <= w_op_byte;
        end
        ST_OP_CMD: if (w_tx_hs) begin
          if (r_write) begin
            r_state   <= ST_WDATA0;
            r_tx_data <= byte_of(r_wdata, 2'd0);
          end else begin
            r_state    <= ST_RDATA0;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_tmo_cnt  <= '0;
          end
        end
        ST_WDATA0, ST_WDATA1, ST_WDATA2: if (w_tx_hs) begin
          r_state   <= htif_state_e'(r_state + 4'd1);
          r_tx_data <= byte_of(r_wdata, w_idx_nxt);
        end
        // No write ack exists on the link: completion is local.
        ST_WDATA3: if (w_tx_hs) begin
          r_state     <= ST_IDLE;
          r_tx_valid  <= 1'b0;
          r_req_ready <= 1'b1;
          r_res_valid <= 1'b1;
          r_res_data  <= '0;
          r_res_error <= 1'b0;
        end
        ST_RDATA0, ST_RDATA1, ST_RDATA2, ST_RDATA3: begin
          if (w_rx_hs) begin
            r_res_data[8*w_idx +: 8] <= rx_data;
            r_tmo_cnt <= '0;
            if (r_state == ST_RDATA3) begin
              r_state     <= ST_IDLE;
              r_rx_ready  <= 1'b0;
              r_req_ready <= 1'b1;
              r_res_valid <= 1'b1;
              r_res_error <= 1'b0;
            end else begin
              r_state <= htif_state_e'(r_state + 4'd1);
            end
          end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b1;
            r_res_data  <= '0;
            r_res_error <= 1'b1;
            r_tmo_cnt   <= w_tmo_nxt;
          end else begin
            r_tmo_cnt <= w_tmo_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_error = r_res_error;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign rx_ready  = r_rx_ready;

endmodule

// File: tb/tb_htif_host.sv
// Scoreboard bench for htif_host (TIMEOUT=16). Expected tx bytes and responses
// are pushed by a small protocol model when a request is issued, and popped by
// a monitor as the DUT produces them. Expectations follow HTIF_ADDR_CACHE_EN.
module tb_htif_host;

`ifdef HTIF_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_ready, req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_address = '0, req_data = '0;
  logic        res_valid, res_error;
  logic [31:0] res_data;
  logic        tx_ready = 1'b1, tx_valid;
  logic [7:0]  tx_data;
  logic        rx_ready, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  htif_host #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req_ready(req_ready), .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .res_valid(res_valid), .res_data(res_data), .res_error(res_error),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] data; logic err; } rsp_t;

  int          total = 0;
  int          bad = 0;
  int          n_rsp = 0;
  logic [7:0]  txq[$];
  rsp_t        rspq[$];
  logic [7:0]  rxq[$];
  bit          stall = 1'b0;
  logic [31:0] m_cur = '0;
  bit          m_valid = 1'b0;

  // Checks every tx byte, tx hold-while-stalled, and every response.
  task automatic monitor();
    logic       pv = 1'b0, prdy = 1'b0, prst = 1'b1;
    logic [7:0] pd = '0;
    logic [7:0] eb;
    rsp_t       er;
    forever begin
      @(negedge clock);
      if (!reset && !prst && pv && !prdy) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          bad++;
          $display("FAIL tx_hold: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, pd);
        end
      end
      if (!reset && tx_valid && tx_ready) begin
        total++;
        if (txq.size() == 0) begin
          bad++;
          $display("FAIL tx_extra: got %h want no byte", tx_data);
        end else begin
          eb = txq.pop_front();
          if (tx_data !== eb) begin
            bad++;
            $display("FAIL tx_byte: got %h want %h", tx_data, eb);
          end
        end
      end
      if (res_valid) begin
        n_rsp++;
        total++;
        if (rspq.size() == 0) begin
          bad++;
          $display("FAIL res_extra: got data=%h err=%b want none", res_data, res_error);
        end else begin
          er = rspq.pop_front();
          if (res_data !== er.data || res_error !== er.err || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL res: got data=%h err=%b rdy=%b want data=%h err=%b rdy=1",
                     res_data, res_error, req_ready, er.data, er.err);
          end
        end
      end
      pv = tx_valid; prdy = tx_ready; pd = tx_data; prst = reset;
    end
  endtask

  // Protocol model: what the link should carry and what should come back.
  task automatic expect_req(input logic w, input logic [31:0] a, d, rd, input bit tmo);
    if (!(CACHE && m_valid && a == m_cur)) begin
      txq.push_back(8'h61);
      for (int i = 0; i < 4; i++) txq.push_back(a[8*i +: 8]);
      m_cur = a;
      m_valid = 1'b1;
    end
    txq.push_back(w ? 8'h77 : 8'h72);
    if (w) for (int i = 0; i < 4; i++) txq.push_back(d[8*i +: 8]);
    rspq.push_back('{data: (w || tmo) ? 32'h0 : rd, err: tmo});
    if (tmo) m_valid = 1'b0;
    else     m_cur = m_cur + 32'd4;
  endtask

  // Issues one request, feeds rx bytes, waits for the response.
  // ntx: tx handshakes seen; span: cycles from first tx byte to response;
  // rlat: cycles from RDATA0 entry (rx_ready rise) to response.
  task automatic do_req(input logic w, input logic [31:0] a, d, rd, input bit tmo,
                        output int ntx, output int span, output int rlat);
    int  budget, cyc, t_tx, t_rx, t_res, nst, seen;
    bit  acc, rxhs;
    expect_req(w, a, d, rd, tmo);
    rxq.delete();
    if (!w && !tmo) for (int i = 0; i < 4; i++) rxq.push_back(rd[8*i +: 8]);
    seen = n_rsp; ntx = 0; cyc = 0; t_tx = -1; t_rx = -1; t_res = -1; nst = 0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_address = a; req_data = d;
    budget = 0;
    do begin
      @(negedge clock); acc = req_ready;
      @(posedge clock); #1; budget++;
    end while (!acc && budget < 50);
    req_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL req_accept: got no req_ready want accept within 50 cycles");
    end
    budget = 0;
    while (n_rsp == seen && budget < 400) begin
      @(negedge clock);
      cyc++;
      rxhs = rx_valid && rx_ready;
      if (tx_valid && tx_ready) ntx++;
      if (tx_valid && t_tx < 0) t_tx = cyc;
      if (rx_ready && t_rx < 0) t_rx = cyc;
      if (res_valid) t_res = cyc;
      @(posedge clock); #1; budget++;
      if (rxhs) begin void'(rxq.pop_front()); rx_valid = 1'b0; end
      if (!rx_valid && rxq.size() > 0) begin
        if (!stall || nst >= 3 || $urandom_range(1, 0) == 1) begin
          rx_valid = 1'b1; rx_data = rxq[0]; nst = 0;
        end else nst++;
      end
      tx_ready = !stall || ($urandom_range(1, 0) == 1);
    end
    rx_valid = 1'b0; tx_ready = 1'b1;
    if (n_rsp == seen) begin
      total++; bad++;
      $display("FAIL res_wait: got no res_valid want response within 400 cycles");
    end
    span = t_res - t_tx;
    rlat = t_res - t_rx;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({req_ready, res_valid, res_error, res_data, tx_valid, tx_data, rx_ready} !== '0) begin
      bad++;
      $display("FAIL reset_vals: got rdy=%b rv=%b re=%b rd=%h tv=%b td=%h rr=%b want all 0",
               req_ready, res_valid, res_error, res_data, tx_valid, tx_data, rx_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release: got req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_write();
    int ntx, span, rlat;
    do_req(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, ntx, span, rlat);
    total++;
    if (ntx !== 10 || span !== 10) begin
      bad++; $display("FAIL write_stream: got ntx=%0d span=%0d want 10 10", ntx, span);
    end
  endtask

  task automatic test_read();
    int ntx, span, rlat;
    do_req(1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 1'b0, ntx, span, rlat);
    total++;
    if (ntx !== (CACHE ? 1 : 6)) begin
      bad++; $display("FAIL read_ntx: got %0d want %0d", ntx, CACHE ? 1 : 6);
    end
  endtask

  task automatic test_cache();
    int ntx, span, rlat;
    do_req(1'b1, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b0, ntx, span, rlat);
    do_req(1'b0, 32'h104, 32'h0, 32'hA1B2_C3D4, 1'b0, ntx, span, rlat);
    total++;
    if (ntx !== (CACHE ? 1 : 6)) begin
      bad++; $display("FAIL cache_hit_ntx: got %0d want %0d", ntx, CACHE ? 1 : 6);
    end
    do_req(1'b0, 32'h200, 32'h0, 32'h0BAD_F00D, 1'b0, ntx, span, rlat);
    total++;
    if (ntx !== 6) begin
      bad++; $display("FAIL cache_miss_ntx: got %0d want 6", ntx);
    end
  endtask

  task automatic test_stall();
    int ntx, span, rlat;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_req(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, ntx, span, rlat);
      do_req(1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 1'b0, ntx, span, rlat);
    end
    stall = 1'b0;
    total++;
    if (txq.size() !== 0 || rspq.size() !== 0) begin
      bad++; $display("FAIL stall_drain: got txq=%0d rspq=%0d want 0 0", txq.size(), rspq.size());
    end
  endtask

  task automatic test_timeout();
    int ntx, span, rlat;
    do_req(1'b0, 32'h500, 32'h0, 32'h0, 1'b1, ntx, span, rlat);
    total++;
    if (rlat !== 16) begin
      bad++; $display("FAIL timeout_lat: got %0d want 16", rlat);
    end
    do_req(1'b0, 32'h500, 32'h0, 32'h5566_7788, 1'b0, ntx, span, rlat);
    total++;
    if (ntx !== 6) begin
      bad++; $display("FAIL timeout_resend: got ntx=%0d want 6", ntx);
    end
  endtask

  task automatic test_reset_mid();
    int target, hs, budget, ntx, span, rlat;
    expect_req(1'b1, 32'h300, 32'h4433_2211, 32'h0, 1'b0);
    target = txq.size() - 3;
    hs = 0; budget = 0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h300; req_data = 32'h4433_2211;
    while (hs < target && budget < 100) begin
      @(negedge clock);
      if (tx_valid && tx_ready) hs++;
      if (req_valid && req_ready) begin @(posedge clock); #1; req_valid = 1'b0; end
      else begin @(posedge clock); #1; end
      budget++;
    end
    tx_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
      bad++; $display("FAIL mid_wdata1: got v=%b d=%h want v=1 d=22", tx_valid, tx_data);
    end
    @(posedge clock); #1;
    txq.delete(); rspq.delete(); m_valid = 1'b0;
    @(negedge clock);
    total++;
    if (tx_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got tv=%b rdy=%b want 0 0", tx_valid, req_ready);
    end
    reset = 1'b0;
    tx_ready = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_release: got req_ready=%b want 1", req_ready);
    end
    do_req(1'b1, 32'h304, 32'h0102_0304, 32'h0, 1'b0, ntx, span, rlat);
    total++;
    if (ntx !== 10) begin
      bad++; $display("FAIL mid_resend: got ntx=%0d want 10", ntx);
    end
  endtask

  task automatic test_wrap();
    int ntx, span, rlat;
    do_req(1'b1, 32'hFFFF_FFFC, 32'h1111_2222, 32'h0, 1'b0, ntx, span, rlat);
    do_req(1'b1, 32'h0000_0000, 32'h3333_4444, 32'h0, 1'b0, ntx, span, rlat);
    total++;
    if (ntx !== (CACHE ? 5 : 10)) begin
      bad++; $display("FAIL wrap_ntx: got %0d want %0d", ntx, CACHE ? 5 : 10);
    end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_write();
    test_read();
    test_cache();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_wrap();
    repeat (3) @(posedge clock);
    total++;
    if (txq.size() !== 0 || rspq.size() !== 0) begin
      bad++; $display("FAIL final_drain: got txq=%0d rspq=%0d want 0 0", txq.size(), rspq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/htif_host.md
Name: htif_host

Overview:
- Host-side initiator for the htif serial byte protocol.
- Accepts single-word read/write requests from a local 32-bit request port and serialises them into command bytes: 'a' A0..A3, 'r', 'w' D0..D3.
- Reassembles the 4-byte read reply into a bus response.
- Sits on the near end of a byte link (UART/FIFO) whose far end is the htif bus bridge. Used by on-chip loaders and test harnesses to drive a remote target's bus.

Parameters:
- TIMEOUT, 1000000: cycles to wait for each read-reply byte before aborting; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_valid  in  1  request present
- req_write  in  1  1 = write, 0 = read
- req_address  in  32  word address; sent verbatim, bits [1:0] expected 0
- req_data  in  32  write data
- res_valid  out  1  one-cycle response pulse
- res_data  out  32  read data; 0 for writes and errors
- res_error  out  1  qualifies res_valid; 1 = read timeout
- tx_ready  in  1  link accepts tx byte
- tx_valid  out  1  tx byte present
- tx_data  out  8  byte to far end
- rx_ready  out  1  block accepts rx byte
- rx_valid  in  1  rx byte present
- rx_data  in  8  byte from far end

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high. All state is registered.
- Reset values: req_ready=0, res_valid=0, res_error=0, res_data=0, tx_valid=0, tx_data=0, rx_ready=0, state=IDLE, addr_valid=0, cur_addr=0.
- States: IDLE, ADDR_CMD, ADDR0-3, OP_CMD, WDATA0-3, RDATA0-3.
- IDLE:
  - req_ready=1. On handshake, latch write, address and data; req_ready drops the next cycle.
  - Next state is ADDR_CMD, or OP_CMD if the address-cache hit applies (see Optional Feature).
- tx handshake rules:
  - tx_valid and tx_data are held stable until tx_ready.
  - The next byte is presented in the cycle after the handshake, so bytes stream back-to-back with no bubble.
- Byte order: every multi-byte field is sent least-significant byte first.
- Transmit sequence:
  - ADDR_CMD sends 'a' (0x61), then ADDR0-3 send address[7:0]..[31:24].
  - After ADDR3, set cur_addr=address and addr_valid=1, then go to OP_CMD.
  - OP_CMD sends 'w' (0x77) or 'r' (0x72).
- Write path:
  - WDATA0-3 send data bytes.
  - When the WDATA3 handshake completes: res_valid=1, res_data=0, res_error=0 in the next cycle; return to IDLE.
  - The protocol has no write ack, so completion is local.
- Read path:
  - After the 'r' handshake, enter RDATA0. rx_ready=1 only in RDATA0-3.
  - Bytes land in res_data[8k+7:8k], LSB byte first.
  - The cycle after the 4th rx handshake: res_valid=1, res_error=0; return to IDLE.
- Address tracking: after every completed r/w, cur_addr += 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). This mirrors the far end's auto-increment.
- Next request: may be accepted in the same cycle res_valid is high, since req_ready is already 1 in IDLE.
- Stray rx bytes: outside RDATA, rx_ready=0, so stray bytes stall and are not consumed.
- Timeout (TIMEOUT>0):
  - A counter clears on entry to RDATA0 and on each rx handshake, and increments every cycle otherwise.
  - When it reaches TIMEOUT: res_valid=1, res_error=1, res_data=0; addr_valid=0; go to IDLE.
- Reset mid-operation: the transfer is abandoned, all outputs return to reset values, and the partial byte stream is not completed. The far end must be resynchronised externally.

Optional Feature:
- Macro HTIF_ADDR_CACHE_EN.
- Defined: in IDLE, if addr_valid && req_address == cur_addr, skip ADDR_CMD..ADDR3 and go straight to OP_CMD. Sequential word accesses then cost 5 bytes instead of 10.
- Undefined: every request sends the full 'a' sequence. cur_addr and addr_valid may be omitted from the RTL.

Decomposition:
- Package htif_pkg holds:
  - command byte constants HTIF_CMD_ADDR 8'h61, HTIF_CMD_READ 8'h72, HTIF_CMD_WRITE 8'h77, HTIF_CMD_READ2 8'h52, HTIF_CMD_WRITE2 8'h57;
  - the state encoding.
- The far-end bridge shares the package.
- No sub-module: a single FSM plus the timeout counter.

Test Plan:
- Write 0x80000000 <= 0xDEADBEEF with tx_ready=1 -> tx bytes 61 00 00 00 80 77 EF BE AD DE back-to-back, then res_valid with res_data=0 and res_error=0.
- Read 0x80000004 -> tx 61 04 00 00 80 72; drive rx 78 56 34 12 -> res_data=0x12345678.
- With HTIF_ADDR_CACHE_EN: write 0x100, then read 0x104 -> second transaction sends only 72. Read 0x200 next -> full 'a' sequence.
- Random tx_ready/rx_valid stalls -> tx_data stable while tx_valid & !tx_ready, byte stream unchanged, same results as above.
- TIMEOUT=16, read with no rx bytes -> res_valid & res_error=1 exactly 16 cycles after RDATA0 entry. Next request to the same address resends 'a'.
- Assert reset during WDATA1 -> tx_valid=0 next cycle, req_ready=1 the cycle after reset drops. Write at cur_addr+4 then sends full 'a' (addr_valid cleared). Address wrap: write 0xFFFFFFFC, then 0x0 with cache enabled -> no 'a' sent.
